// File: rtl/bit_detector_pkg.sv
// Shared definitions for the serial bit-pattern detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default pattern length/value, packet-state enum, counter width helper.
package bitdetector_pkg;

    localparam int DEFAULT_PAT_LEN = 4;
    localparam logic [DEFAULT_PAT_LEN-1:0] DEFAULT_PATTERN = 4'b1011;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PACKET
    } pkt_state_t;

    // Bits needed for a counter that saturates at len.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/bit_detector_if.sv
// Bit-serial stream bundle: input beat (bit + framing) and output flag beat.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both directions; i_ready and o_ready carry the stalls.
// Modports: master = source/sink side driving input beats and o_ready; slave = detector.
interface bit_detector_if;

    logic inp;
    logic i_valid;
    logic i_sop;
    logic i_eop;
    logic i_ready;
    logic outp;
    logic o_valid;
    logic o_sop;
    logic o_eop;
    logic o_ready;

    modport master (
        output inp, i_valid, i_sop, i_eop, o_ready,
        input  i_ready, outp, o_valid, o_sop, o_eop
    );

    modport slave (
        input  inp, i_valid, i_sop, i_eop, o_ready,
        output i_ready, outp, o_valid, o_sop, o_eop
    );

endinterface

// File: rtl/bit_pattern_matcher.sv
// History shift register + saturating bit counter + pattern comparator.
// Latency: match is combinational on the current bit; state updates on the shift edge.
// Backpressure: none; the caller only asserts shift_en for beats it keeps.
// Ports: clk, reset_n (active-high sync), shift_en, clear (restart history), bit_in -> match.
module bit_pattern_matcher
    import bitdetector_pkg::*;
#(
    parameter int                 PAT_LEN = DEFAULT_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic shift_en,
    input  logic clear,
    input  logic bit_in,
    output logic match
);

    localparam int CW = cnt_width(PAT_LEN);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] window;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;

    // Window and count as they will be once the current bit is absorbed, so the
    // comparison already includes this bit. A clear starts a fresh packet with
    // only the current bit in history.
    always_comb begin
        window  = {hist[PAT_LEN-2:0], bit_in};
        cnt_nxt = cnt;
        if (clear) begin
            window  = {{(PAT_LEN-1){1'b0}}, bit_in};
            cnt_nxt = CW'(1);
        end else if (cnt != CW'(PAT_LEN)) begin
            cnt_nxt = cnt + CW'(1);
        end
        match = (cnt_nxt == CW'(PAT_LEN)) && (window == PATTERN);
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            hist <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            hist <= window;
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: rtl/bit_detector.sv
// Streaming detector: one match flag per accepted in-packet bit, framing passed through.
// Latency: accepted bit appears on the output one edge later, held until consumed.
// Backpressure: single output register; i_ready = !reset_n && (!o_valid || o_ready).
// Ports: clk, reset_n (active-high sync reset despite the name), bus (slave modport).
module bit_detector
    import bitdetector_pkg::*;
#(
    parameter int                 PAT_LEN = DEFAULT_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN)
) (
    input  logic           clk,
    input  logic           reset_n,
    bit_detector_if.slave  bus
);

    pkt_state_t state;
    pkt_state_t state_nxt;

    logic accept;
    logic keep;
    logic match;

    logic outp_q;
    logic o_valid_q;
    logic o_sop_q;
    logic o_eop_q;

    // Combinational from o_ready so a drain and a fill can share one cycle.
    assign bus.i_ready = !reset_n && (!o_valid_q || bus.o_ready);
    assign accept      = bus.i_valid && bus.i_ready;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A sop always (re)starts a packet, truncating any open one. Bits seen
    // while idle without sop are swallowed and never reach the matcher.
    always_comb begin
        state_nxt = state;
        keep      = 1'b0;
        if (accept) begin
            if (bus.i_sop) begin
                keep      = 1'b1;
                state_nxt = bus.i_eop ? ST_IDLE : ST_IN_PACKET;
            end else if (state == ST_IN_PACKET) begin
                keep = 1'b1;
                if (bus.i_eop) begin
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    bit_pattern_matcher #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_matcher (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (keep),
        .clear    (bus.i_sop),
        .bit_in   (bus.inp),
        .match    (match)
    );

    // Output payload is zeroed whenever the slot empties, so the flags read 0
    // outside a valid beat without extra gating on the output pins.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            o_valid_q <= 1'b0;
            outp_q    <= 1'b0;
            o_sop_q   <= 1'b0;
            o_eop_q   <= 1'b0;
        end else if (keep) begin
            o_valid_q <= 1'b1;
            outp_q    <= match;
            o_sop_q   <= bus.i_sop;
            o_eop_q   <= bus.i_eop;
        end else if (o_valid_q && bus.o_ready) begin
            o_valid_q <= 1'b0;
            outp_q    <= 1'b0;
            o_sop_q   <= 1'b0;
            o_eop_q   <= 1'b0;
        end
    end

    assign bus.outp    = outp_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_sop   = o_sop_q;
    assign bus.o_eop   = o_eop_q;

endmodule

// File: tb/tb_bit_detector.sv
// Self-checking bench for bit_detector: reference model feeds an expected-beat queue.
// Latency: inputs driven 1 time unit after the rising edge, sampled mid-cycle.
// Backpressure: stalls are injected with o_ready = 0 and output stability is checked.
module tb_bit_detector;

    logic clk;
    logic reset_n;

    bit_detector_if bus ();

    bit_detector dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] sb [$];     // expected {outp, o_sop, o_eop}
    logic       pk [$];     // bits of the packet the model is inside
    logic       in_pkt = 1'b0;

    logic [31:0] got_bits;
    logic [31:0] got_sop;
    logic [31:0] got_eop;
    int          n_out;

    logic       stall_prev = 1'b0;
    logic [2:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: keep the packet's bits and look at the last four directly.
    task automatic model_accept(input logic b, input logic s, input logic e);
        logic m;
        int   n;
        if (s) begin
            pk.delete();
            in_pkt = 1'b1;
        end
        if (in_pkt) begin
            pk.push_back(b);
            n = pk.size();
            m = (n >= 4) && pk[n-4] && !pk[n-3] && pk[n-2] && pk[n-1];
            sb.push_back({m, s, e});
            if (e) in_pkt = 1'b0;
        end
    endtask

    task automatic clear_obs();
        got_bits = '0;
        got_sop  = '0;
        got_eop  = '0;
        n_out    = 0;
    endtask

    // One clock cycle: drive, sample mid-cycle, score, advance past the edge.
    task automatic step(input logic v, input logic b, input logic s, input logic e, input logic r);
        logic [2:0] exp;
        bus.i_valid = v;
        bus.inp     = b;
        bus.i_sop   = s;
        bus.i_eop   = e;
        bus.o_ready = r;
        #4;
        if (stall_prev)
            chk("bp_hold", {bus.o_valid, bus.outp, bus.o_sop, bus.o_eop}, {1'b1, held});
        chk("i_ready", bus.i_ready, !bus.o_valid || bus.o_ready);
        if (!bus.o_valid)
            chk("idle_zero", {bus.outp, bus.o_sop, bus.o_eop}, 3'b000);
        stall_prev = bus.o_valid && !bus.o_ready;
        held       = {bus.outp, bus.o_sop, bus.o_eop};
        if (bus.o_valid && bus.o_ready) begin
            got_bits = {got_bits[30:0], bus.outp};
            got_sop  = {got_sop[30:0], bus.o_sop};
            got_eop  = {got_eop[30:0], bus.o_eop};
            n_out++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                exp = sb.pop_front();
                chk("outp",  bus.outp,  exp[2]);
                chk("o_sop", bus.o_sop, exp[1]);
                chk("o_eop", bus.o_eop, exp[0]);
            end
        end
        if (bus.i_valid && bus.i_ready)
            model_accept(b, s, e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [15:0] bits, input int n, input logic sop_first, input logic eop_last);
        for (int i = 0; i < n; i++)
            step(1'b1, bits[n-1-i], (i == 0) && sop_first, (i == n-1) && eop_last, 1'b1);
    endtask

    task automatic drain();
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sb_empty", sb.size(), 0);
    endtask

    // Two reset cycles with a valid '1' offered: everything must stay quiet.
    task automatic do_reset();
        reset_n     = 1'b1;
        bus.i_valid = 1'b1;
        bus.inp     = 1'b1;
        bus.i_sop   = 1'b1;
        bus.i_eop   = 1'b0;
        bus.o_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) begin
            #4;
            chk("rst_outs", {bus.o_valid, bus.outp, bus.o_sop, bus.o_eop}, 4'b0000);
            chk("rst_i_ready", bus.i_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        reset_n     = 1'b0;
        bus.i_valid = 1'b0;
        in_pkt      = 1'b0;
        stall_prev  = 1'b0;
        pk.delete();
        sb.delete();
        #1;
        chk("rel_i_ready", bus.i_ready, 1'b1);
    endtask

    initial begin
        logic [6:0] ovl;
        logic [3:0] bub;
        ovl = 7'b1011011;
        bub = 4'b1011;

        do_reset();

        // Overlapping matches within one packet.
        clear_obs();
        send_pkt(16'b1011011, 7, 1'b1, 1'b1);
        drain();
        chk("ovl_flags", got_bits, 32'b0001001);
        chk("ovl_sop",   got_sop,  32'b1000000);
        chk("ovl_eop",   got_eop,  32'b0000001);
        chk("ovl_count", n_out, 7);

        // Match must not span the A/B boundary.
        clear_obs();
        send_pkt(16'b101, 3, 1'b1, 1'b1);
        send_pkt(16'b1011, 4, 1'b1, 1'b1);
        drain();
        chk("bnd_flags", got_bits, 32'b0000001);
        chk("bnd_count", n_out, 7);

        // Three-cycle stall mid-packet.
        clear_obs();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                repeat (3) step(1'b1, ovl[6-i], 1'b0, 1'b0, 1'b0);
            end
            step(1'b1, ovl[6-i], i == 0, i == 6, 1'b1);
        end
        drain();
        chk("bp_flags", got_bits, 32'b0001001);
        chk("bp_count", n_out, 7);

        // Bubbles between bits.
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bub[3-i], i == 0, i == 3, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("bub_gap", bus.o_valid, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        drain();
        chk("bub_flags", got_bits, 32'b0001);
        chk("bub_count", n_out, 4);

        // Beats before any sop are discarded.
        clear_obs();
        send_pkt(16'b11, 2, 1'b0, 1'b0);
        drain();
        chk("nosop_count", n_out, 0);

        // Second sop mid-packet restarts history.
        clear_obs();
        send_pkt(16'b101, 3, 1'b1, 1'b0);
        send_pkt(16'b1011, 4, 1'b1, 1'b1);
        drain();
        chk("resop_flags", got_bits, 32'b0000001);
        chk("resop_count", n_out, 7);

        // Reset mid-packet abandons it; following non-sop beats are dropped.
        clear_obs();
        send_pkt(16'b101, 3, 1'b1, 1'b0);
        drain();
        do_reset();
        clear_obs();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        chk("rstpkt_count", n_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
